// File: rtl/ycbcr_skin_bin.sv
// Skin-colour binarizer with per-frame hit count and bounding box, one pixel per in_valid.
// Optional build macro SKIN_Y_GATE_EN additionally requires Y >= Y_MIN for a hit.
module ycbcr_skin_bin #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int CB_MIN = 77,
    parameter int CB_MAX = 127,
    parameter int CR_MIN = 133,
    parameter int CR_MAX = 173,
    parameter int Y_MIN  = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [23:0] d_in,
    input  logic        frame_start,
    output logic        out_valid,
    output logic        pix_bin,
    output logic [23:0] d_out,
    output logic        frame_done,
    output logic [19:0] hit_count,
    output logic        bbox_valid,
    output logic [10:0] x_min,
    output logic [10:0] x_max,
    output logic [10:0] y_min,
    output logic [10:0] y_max
);

    localparam logic [10:0] X_LAST = 11'(IMG_W - 1);
    localparam logic [10:0] Y_LAST = 11'(IMG_H - 1);

    logic [7:0]  pix_y, pix_cb, pix_cr;
    logic        hit;

    logic [10:0] x, y;
    logic [19:0] run_cnt;
    logic [10:0] run_xmin, run_xmax, run_ymin, run_ymax;

    logic [10:0] cx, cy;
    logic [19:0] b_cnt, n_cnt;
    logic [10:0] b_xmin, b_xmax, b_ymin, b_ymax;
    logic [10:0] n_xmin, n_xmax, n_ymin, n_ymax;
    logic        b_empty, last_pix;

    assign pix_y  = d_in[23:16];
    assign pix_cb = d_in[15:8];
    assign pix_cr = d_in[7:0];

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        hit = (pix_cb >= 8'(CB_MIN)) && (pix_cb <= 8'(CB_MAX)) &&
              (pix_cr >= 8'(CR_MIN)) && (pix_cr <= 8'(CR_MAX));
`ifdef SKIN_Y_GATE_EN
        hit = hit && (pix_y >= 8'(Y_MIN));
`endif
    end

    // A frame_start arriving with a pixel makes that pixel (0,0) of a fresh frame.
    always_comb begin
        cx       = frame_start ? 11'd0 : x;
        cy       = frame_start ? 11'd0 : y;
        b_cnt    = frame_start ? 20'd0 : run_cnt;
        b_xmin   = frame_start ? 11'd0 : run_xmin;
        b_xmax   = frame_start ? 11'd0 : run_xmax;
        b_ymin   = frame_start ? 11'd0 : run_ymin;
        b_ymax   = frame_start ? 11'd0 : run_ymax;
        b_empty  = (b_cnt == 20'd0);
        n_cnt    = b_cnt + {19'd0, hit};
        n_xmin   = (hit && (b_empty || cx < b_xmin)) ? cx : b_xmin;
        n_xmax   = (hit && (b_empty || cx > b_xmax)) ? cx : b_xmax;
        n_ymin   = (hit && (b_empty || cy < b_ymin)) ? cy : b_ymin;
        n_ymax   = (hit && (b_empty || cy > b_ymax)) ? cy : b_ymax;
        last_pix = (cx == X_LAST) && (cy == Y_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            pix_bin    <= 1'b0;
            d_out      <= 24'd0;
            frame_done <= 1'b0;
            hit_count  <= 20'd0;
            bbox_valid <= 1'b0;
            x_min      <= 11'd0;
            x_max      <= 11'd0;
            y_min      <= 11'd0;
            y_max      <= 11'd0;
            x          <= 11'd0;
            y          <= 11'd0;
            run_cnt    <= 20'd0;
            run_xmin   <= 11'd0;
            run_xmax   <= 11'd0;
            run_ymin   <= 11'd0;
            run_ymax   <= 11'd0;
        end else begin
            out_valid  <= in_valid;
            frame_done <= 1'b0;
            if (in_valid) begin
                pix_bin <= hit;
                d_out   <= {24{hit}};
                if (last_pix) begin
                    frame_done <= 1'b1;
                    hit_count  <= n_cnt;
                    bbox_valid <= (n_cnt != 20'd0);
                    x_min      <= n_xmin;
                    x_max      <= n_xmax;
                    y_min      <= n_ymin;
                    y_max      <= n_ymax;
                    x          <= 11'd0;
                    y          <= 11'd0;
                    run_cnt    <= 20'd0;
                    run_xmin   <= 11'd0;
                    run_xmax   <= 11'd0;
                    run_ymin   <= 11'd0;
                    run_ymax   <= 11'd0;
                end else begin
                    x        <= (cx == X_LAST) ? 11'd0 : cx + 11'd1;
                    y        <= (cx == X_LAST) ? cy + 11'd1 : cy;
                    run_cnt  <= n_cnt;
                    run_xmin <= n_xmin;
                    run_xmax <= n_xmax;
                    run_ymin <= n_ymin;
                    run_ymax <= n_ymax;
                end
            end else if (frame_start) begin
                x        <= 11'd0;
                y        <= 11'd0;
                run_cnt  <= 20'd0;
                run_xmin <= 11'd0;
                run_xmax <= 11'd0;
                run_ymin <= 11'd0;
                run_ymax <= 11'd0;
            end
        end
    end

endmodule

// File: tb/tb_ycbcr_skin_bin.sv
// Self-checking bench for ycbcr_skin_bin on a 4x3 frame; reference model keeps a list of hit
// coordinates per frame and derives count/bbox from it at frame end.
module tb_ycbcr_skin_bin;

    localparam int W = 4;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [23:0] d_in;
    logic        frame_start;
    logic        out_valid;
    logic        pix_bin;
    logic [23:0] d_out;
    logic        frame_done;
    logic [19:0] hit_count;
    logic        bbox_valid;
    logic [10:0] x_min, x_max, y_min, y_max;

    ycbcr_skin_bin #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .d_in(d_in),
        .frame_start(frame_start), .out_valid(out_valid), .pix_bin(pix_bin),
        .d_out(d_out), .frame_done(frame_done), .hit_count(hit_count),
        .bbox_valid(bbox_valid), .x_min(x_min), .x_max(x_max),
        .y_min(y_min), .y_max(y_max)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: pixel index within frame and hit coordinates seen so far.
    int mp = 0;
    int hx[$];
    int hy[$];
    int e_cnt = 0, e_bv = 0, e_xmin = 0, e_xmax = 0, e_ymin = 0, e_ymax = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input logic [23:0] d);
        int yv, cb, cr;
        bit h;
        yv = int'(d[23:16]);
        cb = int'(d[15:8]);
        cr = int'(d[7:0]);
        h = (cb >= 77 && cb <= 127 && cr >= 133 && cr <= 173);
`ifdef SKIN_Y_GATE_EN
        h = h && (yv >= 40);
`endif
        return h;
    endfunction

    task automatic model_clear();
        mp = 0;
        hx.delete();
        hy.delete();
    endtask

    task automatic model_publish();
        e_cnt = hx.size();
        e_bv = (hx.size() > 0) ? 1 : 0;
        e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
        if (hx.size() > 0) begin
            e_xmin = hx[0]; e_xmax = hx[0]; e_ymin = hy[0]; e_ymax = hy[0];
            foreach (hx[i]) begin
                if (hx[i] < e_xmin) e_xmin = hx[i];
                if (hx[i] > e_xmax) e_xmax = hx[i];
                if (hy[i] < e_ymin) e_ymin = hy[i];
                if (hy[i] > e_ymax) e_ymax = hy[i];
            end
        end
    endtask

    task automatic check_published(input string tag);
        check({tag, ".hit_count"},  32'(hit_count),  32'(e_cnt));
        check({tag, ".bbox_valid"}, 32'(bbox_valid), 32'(e_bv));
        check({tag, ".x_min"},      32'(x_min),      32'(e_xmin));
        check({tag, ".x_max"},      32'(x_max),      32'(e_xmax));
        check({tag, ".y_min"},      32'(y_min),      32'(e_ymin));
        check({tag, ".y_max"},      32'(y_max),      32'(e_ymax));
    endtask

    task automatic send_pixel(input string tag, input logic [23:0] d, input logic fs);
        bit h, done;
        in_valid = 1'b1;
        d_in = d;
        frame_start = fs;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        frame_start = 1'b0;
        if (fs) model_clear();
        h = model_hit(d);
        if (h) begin
            hx.push_back(mp % W);
            hy.push_back(mp / W);
        end
        mp++;
        done = (mp == W * H);
        if (done) begin
            model_publish();
            model_clear();
        end
        check({tag, ".out_valid"},  32'(out_valid),  32'd1);
        check({tag, ".pix_bin"},    32'(pix_bin),    32'(h));
        check({tag, ".d_out"},      32'(d_out),      h ? 32'hFFFFFF : 32'h0);
        check({tag, ".frame_done"}, 32'(frame_done), 32'(done));
        check_published(tag);
    endtask

    task automatic idle(input string tag, input logic fs);
        in_valid = 1'b0;
        frame_start = fs;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        if (fs) model_clear();
        check({tag, ".out_valid"},  32'(out_valid),  32'd0);
        check({tag, ".frame_done"}, 32'(frame_done), 32'd0);
        check_published(tag);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        in_valid = 1'b1;
        d_in = 24'h80_64_96;
        frame_start = 1'b0;
        model_clear();
        e_cnt = 0; e_bv = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check("rst.out_valid",  32'(out_valid),  32'd0);
            check("rst.pix_bin",    32'(pix_bin),    32'd0);
            check("rst.d_out",      32'(d_out),      32'd0);
            check("rst.frame_done", 32'(frame_done), 32'd0);
            check_published("rst");
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        idle("post_rst", 1'b0);
        idle("post_rst2", 1'b0);
    endtask

    function automatic logic [23:0] hit_pix();
        return {8'($urandom_range(40, 255)), 8'($urandom_range(77, 127)), 8'($urandom_range(133, 173))};
    endfunction

    function automatic logic [23:0] miss_pix();
        return {8'($urandom), 8'($urandom_range(0, 76)), 8'($urandom)};
    endfunction

    function automatic logic [23:0] rnd_pix();
        return {8'($urandom), 8'($urandom_range(60, 140)), 8'($urandom_range(120, 190))};
    endfunction

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        d_in = 24'd0;
        frame_start = 1'b0;

        do_reset(3);

        // Classification boundaries (occupy raster positions 0..3).
        send_pixel("bnd_77_133",  24'h50_4D_85, 1'b0);
        send_pixel("bnd_127_173", 24'h50_7F_AD, 1'b0);
        send_pixel("bnd_76_150",  24'h50_4C_96, 1'b0);
        send_pixel("bnd_100_174", 24'h50_64_AE, 1'b0);
        idle("resync", 1'b1);

        // Full frame, hits only at (1,0), (2,1), (3,2).
        for (int p = 0; p < W * H; p++) begin
            send_pixel("frame1", (p == 1 || p == 6 || p == 11) ? hit_pix() : miss_pix(), 1'b0);
        end
        check("frame1.count_const", 32'(hit_count), 32'd3);
        check("frame1.xmax_const",  32'(x_max),      32'd3);

        // Empty frame; previous results must hold until its frame_done.
        for (int p = 0; p < W * H; p++) send_pixel("empty", miss_pix(), 1'b0);

        // Abort at pixel 5 with a simultaneous frame_start carrying a hit.
        for (int p = 0; p < 4; p++) send_pixel("abort_old", rnd_pix(), 1'b0);
        send_pixel("abort_fs", hit_pix(), 1'b1);
        for (int p = 1; p < W * H; p++) send_pixel("abort_new", rnd_pix(), 1'b0);
        check("abort.xmin_const", 32'(x_min), 32'd0);
        check("abort.ymin_const", 32'(y_min), 32'd0);

        // Luma gate.
        send_pixel("ygate_39", 24'h27_64_96, 1'b0);
        send_pixel("ygate_40", 24'h28_64_96, 1'b0);
`ifdef SKIN_Y_GATE_EN
        check("ygate_40.bin_const", 32'(pix_bin), 32'd1);
`else
        check("ygate_40.bin_const", 32'(pix_bin), 32'd1);
`endif
        idle("resync2", 1'b1);

        // Random frames with random idle gaps.
        for (int f = 0; f < 4; f++) begin
            for (int p = 0; p < W * H; p++) begin
                if ($urandom_range(0, 3) == 0) idle("rnd_gap", 1'b0);
                send_pixel("rnd", rnd_pix(), 1'b0);
            end
        end

        // Reset mid-frame discards the partial frame; next pixel is (0,0).
        for (int p = 0; p < 5; p++) send_pixel("pre_rst", rnd_pix(), 1'b0);
        do_reset(2);
        for (int p = 0; p < W * H; p++) send_pixel("post_rst_frame", (p == 0) ? hit_pix() : rnd_pix(), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
